parking_gate_arbiter: RTL and testbench
=======================================

// Module: parking_gate_arbiter
// PURPOSE
//   Shares one physical barrier gate between the entrance lane (car already
//   password-cleared) and the exit lane. Arbitrates requests, sequences the
//   gate open/pass/close cycle, tracks lot occupancy against capacity, and
//   flags full/empty. Sits between the per-lane access FSMs and the gate driver.
// PARAMETERS
//   CAPACITY       8   number of spaces; entry refused when occupancy==CAPACITY
//   CNT_W          4   occupancy width; must satisfy 2**CNT_W > CAPACITY
//   OPEN_CYCLES    4   cycles spent in OPENING and in CLOSING (>=1)
//   PASS_TIMEOUT   16  max cycles in PASSING waiting for car_passed (>=1)
// PORTS
//   clk           in   1      system clock, rising edge
//   reset         in   1      asynchronous, active-high reset
//   entry_req     in   1      level: cleared car waiting at entrance
//   exit_req      in   1      level: car waiting at exit
//   car_passed    in   1      gate loop sensor: car crossed (sampled, 1 cycle)
//   entry_grant   out  1      entrance lane owns gate (OPENING..CLOSING)
//   exit_grant    out  1      exit lane owns gate (OPENING..CLOSING)
//   gate_open     out  1      gate drive command: 1 in OPENING and PASSING
//   occupancy     out  CNT_W  cars currently parked
//   lot_full      out  1      occupancy==CAPACITY
//   lot_empty     out  1      occupancy==0
//   timeout_err   out  1      1-cycle pulse: PASSING expired without car
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, all grants/gate_open/timeout_err=0,
//     occupancy=0, lot_empty=1, lot_full=0, last_served=EXIT, timers=0.
//   All outputs registered; lot_full/lot_empty decoded from registered count.
//   FSM: IDLE -> OPENING -> PASSING -> CLOSING -> IDLE.
//   IDLE: elig_in = entry_req & ~lot_full; elig_out = exit_req & ~lot_empty.
//     One eligible -> grant it. Both -> grant lane != last_served (round robin),
//     so first contest after reset goes to ENTRY. None -> stay IDLE.
//     Req sampled at edge N -> grant, gate_open=1, state OPENING from edge N+1.
//     last_served updated when grant issued.
//   OPENING: exactly OPEN_CYCLES cycles, then PASSING.
//   PASSING: gate_open=1. car_passed=1 -> occupancy +1 (entry) or -1 (exit)
//     at same edge as move to CLOSING. No car_passed after PASS_TIMEOUT cycles
//     -> CLOSING, occupancy unchanged, timeout_err=1 for one cycle.
//     car_passed on the final timeout cycle: counts, no timeout_err.
//   CLOSING: gate_open=0, grant held; OPEN_CYCLES cycles then IDLE, grant
//     dropped. IDLE re-arbitrates on first IDLE cycle (min 1 cycle in IDLE).
//   Grant is one-hot or zero; never both. Exactly one lane per gate cycle.
//   Request deassert after grant is ignored; cycle runs to completion.
//   car_passed outside PASSING ignored; counts at most once per cycle.
//   No wrap: entry never granted when full, exit never granted when empty,
//     so occupancy stays in [0, CAPACITY].
// TESTING
//   T1 reset, entry_req=1 at edge 0 -> entry_grant=1,gate_open=1 from edge 1;
//      PASSING after 4 cycles; car_passed -> occupancy 0->1, lot_empty->0,
//      gate_open=0, grant drops 4 cycles later.
//   T2 occ=3, entry_req=exit_req=1 continuously, car_passed each PASSING ->
//      grants alternate ENTRY,EXIT,ENTRY,EXIT; occupancy 4,3,4,3.
//   T3 fill to 8: lot_full=1; entry_req=1 alone -> no grant ever;
//      exit_req added -> exit_grant; after pass occupancy=7, lot_full=0.
//   T4 empty lot, exit_req=1 -> no grant; entry granted, no car_passed for
//      16 PASSING cycles -> timeout_err single pulse, occupancy stays 0.
//   T5 car_passed on 16th PASSING cycle -> counted, timeout_err stays 0;
//      car_passed during OPENING/CLOSING/IDLE -> occupancy unchanged.
//   T6 assert reset mid-PASSING with occ=5 -> immediately gate_open=0,
//      grants=0, occupancy=0, lot_empty=1; post-reset contest grants ENTRY.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter
//   Shares one barrier gate between the entrance lane (car already cleared)
//   and the exit lane. Arbitrates round-robin when both lanes are eligible,
//   sequences the gate through open/pass/close, and tracks lot occupancy.
// Ports
//   clk          rising-edge system clock
//   reset        asynchronous active-high reset
//   entry_req    level request from the entrance lane
//   exit_req     level request from the exit lane
//   car_passed   loop sensor pulse, only honoured while the gate is passing
//   entry_grant  entrance lane owns the gate (opening through closing)
//   exit_grant   exit lane owns the gate (opening through closing)
//   gate_open    gate drive command, high while opening and passing
//   occupancy    cars currently parked
//   lot_full     occupancy equals CAPACITY
//   lot_empty    occupancy equals zero
//   timeout_err  one-cycle pulse when passing expires without a car
module parking_gate_arbiter #(
   parameter int unsigned CAPACITY     = 8,
   parameter int unsigned CNT_W        = 4,
   parameter int unsigned OPEN_CYCLES  = 4,
   parameter int unsigned PASS_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             car_passed,
   output logic             entry_grant,
   output logic             exit_grant,
   output logic             gate_open,
   output logic [CNT_W-1:0] occupancy,
   output logic             lot_full,
   output logic             lot_empty,
   output logic             timeout_err
);

   localparam int unsigned TMAX  = (OPEN_CYCLES > PASS_TIMEOUT) ? OPEN_CYCLES : PASS_TIMEOUT;
   localparam int unsigned TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0] PASS_LAST = TMR_W'(PASS_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);

   typedef enum logic [1:0] {StIdle, StOpening, StPassing, StClosing} state_e;
   typedef enum logic {LaneEntry, LaneExit} lane_e;

   state_e           state_q, state_d;
   lane_e            lane_q, lane_d;
   lane_e            last_q, last_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             entry_grant_q, entry_grant_d;
   logic             exit_grant_q, exit_grant_d;
   logic             gate_open_q, gate_open_d;
   logic             timeout_q, timeout_d;
   logic             elig_in, elig_out;

   // Full/empty come straight from the registered count.
   assign lot_full    = (occ_q == CAP_VAL);
   assign lot_empty   = (occ_q == '0);
   assign occupancy   = occ_q;
   assign entry_grant = entry_grant_q;
   assign exit_grant  = exit_grant_q;
   assign gate_open   = gate_open_q;
   assign timeout_err = timeout_q;

   // Eligibility masks keep occupancy inside [0, CAPACITY].
   assign elig_in  = entry_req & ~lot_full;
   assign elig_out = exit_req & ~lot_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         lane_q        <= LaneEntry;
         last_q        <= LaneExit;
         timer_q       <= '0;
         occ_q         <= '0;
         entry_grant_q <= 1'b0;
         exit_grant_q  <= 1'b0;
         gate_open_q   <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         lane_q        <= lane_d;
         last_q        <= last_d;
         timer_q       <= timer_d;
         occ_q         <= occ_d;
         entry_grant_q <= entry_grant_d;
         exit_grant_q  <= exit_grant_d;
         gate_open_q   <= gate_open_d;
         timeout_q     <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      last_d  = last_q;
      timer_d = timer_q;
      occ_d   = occ_q;
      case (state_q)
         StIdle: begin
            timer_d = '0;
            if (elig_in || elig_out) begin
               state_d = StOpening;
               // Contested: serve the lane that did not go last.
               if (elig_in && elig_out) begin
                  lane_d = (last_q == LaneExit) ? LaneEntry : LaneExit;
               end else begin
                  lane_d = elig_in ? LaneEntry : LaneExit;
               end
               last_d = lane_d;
            end
         end
         StOpening: begin
            if (timer_q == OPEN_LAST) begin
               state_d = StPassing;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         StPassing: begin
            // A car on the final cycle still counts and suppresses the timeout.
            if (car_passed) begin
               occ_d   = (lane_q == LaneEntry) ? occ_q + CNT_W'(1) : occ_q - CNT_W'(1);
               state_d = StClosing;
               timer_d = '0;
            end else if (timer_q == PASS_LAST) begin
               state_d = StClosing;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         StClosing: begin
            if (timer_q == OPEN_LAST) begin
               state_d = StIdle;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
   end

   // Outputs are registered, so decode them from the next state.
   always_comb begin
      entry_grant_d = (state_d != StIdle) && (lane_d == LaneEntry);
      exit_grant_d  = (state_d != StIdle) && (lane_d == LaneExit);
      gate_open_d   = (state_d == StOpening) || (state_d == StPassing);
      timeout_d     = (state_q == StPassing) && !car_passed && (timer_q == PASS_LAST);
   end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
module tb_parking_gate_arbiter;

   localparam int CAP = 8;
   localparam int OPN = 4;
   localparam int PT  = 16;
   localparam int MI  = 0;
   localparam int MO  = 1;
   localparam int MP  = 2;
   localparam int MC  = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       entry_req = 1'b0;
   logic       exit_req = 1'b0;
   logic       car_passed = 1'b0;
   logic       entry_grant, exit_grant, gate_open, lot_full, lot_empty, timeout_err;
   logic [3:0] occupancy;

   parking_gate_arbiter #(
      .CAPACITY    (CAP),
      .CNT_W       (4),
      .OPEN_CYCLES (OPN),
      .PASS_TIMEOUT(PT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .entry_req  (entry_req),
      .exit_req   (exit_req),
      .car_passed (car_passed),
      .entry_grant(entry_grant),
      .exit_grant (exit_grant),
      .gate_open  (gate_open),
      .occupancy  (occupancy),
      .lot_full   (lot_full),
      .lot_empty  (lot_empty),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       eg;
      logic       xg;
      logic       go;
      logic [3:0] occ;
      logic       full;
      logic       empty;
      logic       terr;
   } exp_t;

   typedef struct packed {
      logic       en;
      logic       ex;
      logic       car;
      logic       eg;
      logic       xg;
      logic       go;
      logic [3:0] occ;
      logic       terr;
   } vec_t;

   int    total = 0;
   int    bad = 0;
   exp_t  sb[$];
   vec_t  tbl[11];
   string cur_name = "reset";

   // Reference model, countdown style.
   int m_state, m_cnt, m_occ;
   bit m_lane, m_last, m_to;
   bit saw_e, saw_x;
   int n_to;

   function automatic vec_t mk(bit en, bit ex, bit car, bit eg, bit xg, bit go, int occ);
      vec_t v;
      v.en = en; v.ex = ex; v.car = car; v.eg = eg; v.xg = xg; v.go = go;
      v.occ = 4'(occ); v.terr = 1'b0;
      return v;
   endfunction

   function automatic exp_t model_out();
      exp_t r;
      r.eg    = (m_state != MI) && !m_lane;
      r.xg    = (m_state != MI) && m_lane;
      r.go    = (m_state == MO) || (m_state == MP);
      r.occ   = 4'(m_occ);
      r.full  = (m_occ == CAP);
      r.empty = (m_occ == 0);
      r.terr  = m_to;
      return r;
   endfunction

   function automatic exp_t dut_out();
      exp_t a;
      a = {entry_grant, exit_grant, gate_open, occupancy, lot_full, lot_empty, timeout_err};
      return a;
   endfunction

   task automatic model_reset();
      m_state = MI; m_cnt = 0; m_lane = 1'b0; m_last = 1'b1; m_occ = 0; m_to = 1'b0;
   endtask

   task automatic model_step(input bit e, input bit x, input bit c);
      bit ei, xi;
      m_to = 1'b0;
      case (m_state)
         MI: begin
            ei = e && (m_occ != CAP);
            xi = x && (m_occ != 0);
            if (ei || xi) begin
               if (ei && xi) m_lane = ~m_last;
               else m_lane = xi;
               m_last  = m_lane;
               m_state = MO;
               m_cnt   = OPN;
            end
         end
         MO: begin
            m_cnt--;
            if (m_cnt == 0) begin m_state = MP; m_cnt = PT; end
         end
         MP: begin
            if (c) begin
               if (m_lane) m_occ--; else m_occ++;
               m_state = MC; m_cnt = OPN;
            end else begin
               m_cnt--;
               if (m_cnt == 0) begin m_state = MC; m_cnt = OPN; m_to = 1'b1; end
            end
         end
         default: begin
            m_cnt--;
            if (m_cnt == 0) m_state = MI;
         end
      endcase
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // Drive one cycle; expected result is queued now and popped after the edge.
   task automatic step(input bit e, input bit x, input bit c, input bit from_tbl,
                       input exp_t texp);
      exp_t w;
      entry_req = e; exit_req = x; car_passed = c;
      model_step(e, x, c);
      sb.push_back(from_tbl ? texp : model_out());
      @(posedge clk);
      #1;
      w = sb.pop_front();
      check(cur_name, 32'(dut_out()), 32'(w));
      if (entry_grant) saw_e = 1'b1;
      if (exit_grant) saw_x = 1'b1;
      if (timeout_err) n_to++;
   endtask

   // One full gate cycle; car_at is the PASSING cycle index for the car (-1: none).
   task automatic run_gate(input bit e, input bit x, input int car_at, input bit noise);
      bit started, done, c;
      started = 1'b0; done = 1'b0;
      saw_e = 1'b0; saw_x = 1'b0; n_to = 0;
      for (int k = 0; k < 80 && !done; k++) begin
         c = 1'b0;
         if (m_state == MP && car_at >= 0 && (PT - m_cnt) == car_at) c = 1'b1;
         if (noise && m_state != MP) c = 1'b1;
         step(e, x, c, 1'b0, '0);
         if (m_state != MI) started = 1'b1;
         else if (started) done = 1'b1;
      end
      check({cur_name, "_bound"}, 32'(done), 32'd1);
   endtask

   task automatic idle_run(input bit e, input bit x, input bit c, input int n);
      saw_e = 1'b0; saw_x = 1'b0; n_to = 0;
      for (int k = 0; k < n; k++) step(e, x, c, 1'b0, '0);
   endtask

   initial begin
      exp_t te;
      bit   reached;

      // T1 vectors: inputs, then grants/gate/occupancy seen after the edge.
      tbl[0]  = mk(1, 0, 0, 1, 0, 1, 0);
      tbl[1]  = mk(0, 0, 0, 1, 0, 1, 0);
      tbl[2]  = mk(0, 0, 0, 1, 0, 1, 0);
      tbl[3]  = mk(0, 0, 0, 1, 0, 1, 0);
      tbl[4]  = mk(0, 0, 0, 1, 0, 1, 0);
      tbl[5]  = mk(0, 0, 1, 1, 0, 0, 1);
      tbl[6]  = mk(0, 0, 0, 1, 0, 0, 1);
      tbl[7]  = mk(0, 0, 0, 1, 0, 0, 1);
      tbl[8]  = mk(0, 0, 0, 1, 0, 0, 1);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1);
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 1);

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 32'(dut_out()), 32'(model_out()));
      @(negedge clk);
      reset = 1'b0;

      cur_name = "t1_table";
      for (int i = 0; i < 11; i++) begin
         te.eg = tbl[i].eg; te.xg = tbl[i].xg; te.go = tbl[i].go; te.occ = tbl[i].occ;
         te.full = (tbl[i].occ == 4'(CAP)); te.empty = (tbl[i].occ == 4'd0);
         te.terr = tbl[i].terr;
         step(tbl[i].en, tbl[i].ex, tbl[i].car, 1'b1, te);
      end

      // Bring occupancy to 3 with the exit lane served last.
      cur_name = "t2_prep";
      for (int i = 0; i < 3; i++) run_gate(1'b1, 1'b0, 0, 1'b0);
      run_gate(1'b0, 1'b1, 0, 1'b0);
      check("t2_start_occ", 32'(occupancy), 32'd3);

      cur_name = "t2_rr";
      for (int i = 0; i < 4; i++) begin
         run_gate(1'b1, 1'b1, 0, 1'b0);
         check("t2_lane", 32'({saw_e, saw_x}), (i % 2 == 0) ? 32'd2 : 32'd1);
         check("t2_occ", 32'(occupancy), (i % 2 == 0) ? 32'd4 : 32'd3);
      end

      cur_name = "t3_fill";
      for (int i = 0; i < 5; i++) run_gate(1'b1, 1'b0, 2, 1'b0);
      check("t3_full", 32'({lot_full, occupancy}), 32'h18);
      cur_name = "t3_full_hold";
      idle_run(1'b1, 1'b0, 1'b0, 10);
      check("t3_no_entry", 32'(saw_e), 32'd0);
      cur_name = "t3_exit";
      run_gate(1'b1, 1'b1, 0, 1'b0);
      check("t3_exit_lane", 32'({saw_e, saw_x}), 32'd1);
      check("t3_after", 32'({lot_full, occupancy}), 32'h07);

      cur_name = "t4_drain";
      for (int i = 0; i < 7; i++) run_gate(1'b0, 1'b1, 1, 1'b0);
      check("t4_empty", 32'({lot_empty, occupancy}), 32'h10);
      cur_name = "t4_empty_hold";
      idle_run(1'b0, 1'b1, 1'b0, 10);
      check("t4_no_exit", 32'(saw_x), 32'd0);
      cur_name = "t4_timeout";
      run_gate(1'b1, 1'b0, -1, 1'b0);
      check("t4_pulses", 32'(n_to), 32'd1);
      check("t4_occ", 32'(occupancy), 32'd0);

      cur_name = "t5_last_cycle";
      run_gate(1'b1, 1'b0, PT - 1, 1'b1);
      check("t5_pulses", 32'(n_to), 32'd0);
      check("t5_occ", 32'(occupancy), 32'd1);
      cur_name = "t5_idle_noise";
      idle_run(1'b0, 1'b0, 1'b1, 5);
      check("t5_idle_occ", 32'(occupancy), 32'd1);

      cur_name = "t6_prep";
      for (int i = 0; i < 4; i++) run_gate(1'b1, 1'b0, 0, 1'b0);
      check("t6_occ5", 32'(occupancy), 32'd5);
      cur_name = "t6_to_pass";
      reached = 1'b0;
      for (int k = 0; k < 20 && !reached; k++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, '0);
         if (m_state == MP) reached = 1'b1;
      end
      check("t6_reached_pass", 32'(reached), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("t6_async_reset", 32'(dut_out()), 32'(model_out()));
      @(negedge clk);
      reset = 1'b0;
      cur_name = "t6_post";
      run_gate(1'b1, 1'b1, 0, 1'b0);
      check("t6_first_contest", 32'({saw_e, saw_x}), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
